// File: rtl/vdc_pkg.sv
// Shared definitions for the VDC pixel path: attribute bit positions and colour type.
package vdc_pkg;

    localparam int unsigned ATR_REV   = 6;
    localparam int unsigned ATR_UL    = 5;
    localparam int unsigned ATR_BLINK = 4;

    localparam int unsigned RGBI_W = 4;

    typedef logic [RGBI_W-1:0] rgbi_t;

endpackage

// File: rtl/vdc_pixelgen_if.sv
// Fetch-side latches, timing strobes, register file view and pixel output of the pixel generator.
interface vdc_pixelgen_if #(
    parameter int unsigned C_LATCH_WIDTH = 8,
    parameter int unsigned S_LATCH_WIDTH = 128
);
    import vdc_pkg::*;

    logic                                   enable;
    logic                                   newCol;
    logic                                   lineStart;
    logic                                   frameStart;
    logic                                   visible;
    logic [4:0]                             line;
    logic                                   rowbuf;
    logic [C_LATCH_WIDTH-1:0][7:0]          charbuf;
    logic [1:0][S_LATCH_WIDTH-1:0][7:0]     attrbuf;
    logic [3:0]                             reg_cth;
    logic [3:0]                             reg_cdh;
    rgbi_t                                  reg_fg;
    rgbi_t                                  reg_bg;
    logic                                   reg_rvs;
    logic                                   reg_atr;
    logic                                   reg_text;
    logic                                   reg_semi;
    logic                                   reg_dbl;
    logic [4:0]                             reg_ul;
    logic                                   reg_cbrate;
    rgbi_t                                  rgbi;

    modport master (
        output enable, newCol, lineStart, frameStart, visible, line, rowbuf,
               charbuf, attrbuf, reg_cth, reg_cdh, reg_fg, reg_bg, reg_rvs,
               reg_atr, reg_text, reg_semi, reg_dbl, reg_ul, reg_cbrate,
        input  rgbi
    );

    modport slave (
        input  enable, newCol, lineStart, frameStart, visible, line, rowbuf,
               charbuf, attrbuf, reg_cth, reg_cdh, reg_fg, reg_bg, reg_rvs,
               reg_atr, reg_text, reg_semi, reg_dbl, reg_ul, reg_cbrate,
        output rgbi
    );

endinterface

// File: rtl/vdc_blink.sv
// Frame counter for character blink; phase selects the 1/16 or 1/32 frame rate.
module vdc_blink
    import vdc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_frame_start,
    input  logic i_cbrate,
    output logic o_phase_c
);

    localparam int unsigned CNT_W = 5;

    logic [CNT_W-1:0] r_cnt;

    // Count frames on qualified frame-start strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_enable && i_frame_start) begin
            r_cnt <= CNT_W'(r_cnt + 1'b1);
        end
    end

    assign o_phase_c = i_cbrate ? r_cnt[4] : r_cnt[3];

endmodule

// File: rtl/vdc_pixelgen.sv
// Serialises latched character bitmaps and attributes into one RGBI pixel per pixel-clock enable.
module vdc_pixelgen
    import vdc_pkg::*;
#(
    parameter int unsigned C_LATCH_WIDTH = 8,
    parameter int unsigned S_LATCH_WIDTH = 128
) (
    input  logic           clk,
    input  logic           reset,
    vdc_pixelgen_if.slave  bus
);

    localparam int unsigned C_LATCH_BITS = $clog2(C_LATCH_WIDTH);
    localparam int unsigned S_LATCH_BITS = $clog2(S_LATCH_WIDTH);
    localparam int unsigned PX_W         = 4;

    logic [C_LATCH_BITS-1:0] r_ci;
    logic [C_LATCH_BITS-1:0] w_ci_base;
    logic [C_LATCH_BITS-1:0] w_ci_n;
    logic [S_LATCH_BITS-1:0] r_ai;
    logic [S_LATCH_BITS-1:0] w_ai_base;
    logic [S_LATCH_BITS-1:0] w_ai_n;
    logic [7:0]              r_chr;
    logic [7:0]              w_chr;
    logic [7:0]              r_atr;
    logic [7:0]              w_atr;
    logic [PX_W-1:0]         r_px;
    logic [PX_W-1:0]         w_px;
    logic                    r_dph;
    logic                    w_dph;
    rgbi_t                   r_rgbi;
    rgbi_t                   w_pix;
    rgbi_t                   w_fg;
    rgbi_t                   w_bg;
    logic                    w_load;
    logic                    w_bit;
    logic                    w_phase;

    vdc_blink u_blink (
        .clk           (clk),
        .reset         (reset),
        .i_enable      (bus.enable),
        .i_frame_start (bus.frameStart),
        .i_cbrate      (bus.reg_cbrate),
        .o_phase_c     (w_phase)
    );

    // Cell load and pixel-index advance; a load bypasses the latches so pixel 0 uses fresh data.
    always_comb begin
        w_ci_base = bus.lineStart ? '0 : r_ci;
        w_ai_base = bus.lineStart ? '0 : r_ai;
        w_load    = bus.newCol && bus.visible;
        w_ci_n    = w_ci_base;
        w_ai_n    = w_ai_base;
        w_chr     = r_chr;
        w_atr     = r_atr;
        w_px      = r_px;
        w_dph     = r_dph;
        if (w_load) begin
            w_chr  = bus.charbuf[w_ci_base];
            w_atr  = bus.reg_atr ? bus.attrbuf[bus.rowbuf][w_ai_base] : {4'h0, bus.reg_fg};
            w_ci_n = (w_ci_base == C_LATCH_BITS'(C_LATCH_WIDTH - 1)) ? '0
                                                                     : C_LATCH_BITS'(w_ci_base + 1'b1);
            w_ai_n = S_LATCH_BITS'(w_ai_base + 1'b1);
            w_px   = '0;
            w_dph  = 1'b0;
        end else if (bus.visible) begin
            if (bus.reg_dbl) begin
                w_dph = ~r_dph;
            end
            if (!bus.reg_dbl || r_dph) begin
                w_px = (r_px < bus.reg_cth) ? PX_W'(r_px + 1'b1) : r_px;
            end
        end
    end

    // Pixel colour from bitmap bit, attributes, blink phase and displayed width.
    always_comb begin
        w_fg  = bus.reg_fg;
        w_bg  = bus.reg_bg;
        w_bit = 1'b0;
        w_pix = bus.reg_bg;
        if (w_px[3]) begin
            w_bit = bus.reg_semi & w_chr[0];
        end else begin
            w_bit = w_chr[3'(3'd7 - w_px[2:0])];
        end
        if (!bus.reg_text) begin
            if (w_atr[ATR_UL] && (bus.line == bus.reg_ul)) begin
                w_bit = 1'b1;
            end
            if (w_atr[ATR_BLINK] && !w_phase) begin
                w_bit = 1'b0;
            end
            w_bit = w_bit ^ w_atr[ATR_REV] ^ bus.reg_rvs;
            if (bus.reg_atr) begin
                w_fg = w_atr[3:0];
            end
        end else begin
            w_bit = w_bit ^ bus.reg_rvs;
            if (bus.reg_atr) begin
                w_fg = w_atr[3:0];
                w_bg = w_atr[7:4];
            end
        end
        if (!bus.visible) begin
            w_pix = bus.reg_bg;
        end else if (w_px >= bus.reg_cdh) begin
            w_pix = w_bg;
        end else begin
            w_pix = w_bit ? w_fg : w_bg;
        end
    end

    // Pixel-pipeline state; everything holds between enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ci   <= '0;
            r_ai   <= '0;
            r_chr  <= '0;
            r_atr  <= '0;
            r_px   <= '0;
            r_dph  <= 1'b0;
            r_rgbi <= '0;
        end else if (bus.enable) begin
            r_ci   <= w_ci_n;
            r_ai   <= w_ai_n;
            r_chr  <= w_chr;
            r_atr  <= w_atr;
            r_px   <= w_px;
            r_dph  <= w_dph;
            r_rgbi <= w_pix;
        end
    end

    assign bus.rgbi = r_rgbi;

endmodule

// File: tb/tb_vdc_pixelgen.sv
// Self-checking bench for vdc_pixelgen: directed cases plus randomized cells against a reference model.
module tb_vdc_pixelgen;
    import vdc_pkg::*;

    localparam int unsigned CW = 8;
    localparam int unsigned SW = 128;

    logic clk;
    logic reset;

    vdc_pixelgen_if #(.C_LATCH_WIDTH(CW), .S_LATCH_WIDTH(SW)) bus ();

    vdc_pixelgen #(.C_LATCH_WIDTH(CW), .S_LATCH_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;

    // Reference model state
    int         m_ci;
    int         m_ai;
    int         m_n;
    int         m_frames;
    logic [7:0] m_chr;
    logic [7:0] m_atr;
    rgbi_t      m_rgbi;

    task automatic chk(input string tag, input rgbi_t got, input rgbi_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic rgbi_t ref_pix(input int px, input bit ph);
        int    b;
        rgbi_t fg;
        rgbi_t bg;
        b = (px < 8) ? int'(m_chr[7-px]) : int'(bus.reg_semi & m_chr[0]);
        if (!bus.reg_text) begin
            if (m_atr[5] && bus.line == bus.reg_ul) b = 1;
            if (m_atr[4] && !ph) b = 0;
            b = b ^ int'(m_atr[6]) ^ int'(bus.reg_rvs);
            fg = bus.reg_atr ? m_atr[3:0] : bus.reg_fg;
            bg = bus.reg_bg;
        end else begin
            b = b ^ int'(bus.reg_rvs);
            fg = bus.reg_atr ? m_atr[3:0] : bus.reg_fg;
            bg = bus.reg_atr ? m_atr[7:4] : bus.reg_bg;
        end
        if (px >= int'(bus.reg_cdh)) return bg;
        return (b != 0) ? fg : bg;
    endfunction

    // Advance the model with the inputs about to be sampled.
    task automatic model_step();
        int px;
        bit ph;
        if (reset) begin
            m_ci = 0; m_ai = 0; m_n = 0; m_frames = 0;
            m_chr = '0; m_atr = '0; m_rgbi = '0;
        end else if (bus.enable) begin
            ph = (((m_frames % 32) / (bus.reg_cbrate ? 16 : 8)) % 2) == 1;
            if (bus.frameStart) m_frames++;
            if (bus.lineStart) begin
                m_ci = 0;
                m_ai = 0;
            end
            if (bus.visible) begin
                if (bus.newCol) begin
                    m_chr = bus.charbuf[m_ci];
                    m_atr = bus.reg_atr ? bus.attrbuf[bus.rowbuf][m_ai] : {4'h0, bus.reg_fg};
                    m_ci  = (m_ci + 1) % CW;
                    m_ai  = (m_ai + 1) % SW;
                    m_n   = 0;
                end else begin
                    m_n++;
                end
                px = bus.reg_dbl ? m_n / 2 : m_n;
                if (px > int'(bus.reg_cth)) px = int'(bus.reg_cth);
                m_rgbi = ref_pix(px, ph);
            end else begin
                m_rgbi = bus.reg_bg;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model", bus.rgbi, m_rgbi);
    endtask

    task automatic pix(input bit nc, input bit ls, input bit fs);
        bus.enable     = 1'b1;
        bus.visible    = 1'b1;
        bus.newCol     = nc;
        bus.lineStart  = ls;
        bus.frameStart = fs;
        tick();
        bus.newCol     = 1'b0;
        bus.lineStart  = 1'b0;
        bus.frameStart = 1'b0;
    endtask

    task automatic fill(input logic [7:0] c, input logic [7:0] a);
        for (int i = 0; i < CW; i++) bus.charbuf[i] = c;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < SW; i++) bus.attrbuf[r][i] = a;
    endtask

    // One cell of n pixels; exp holds pixel 0 in the most significant used nibble.
    task automatic run_cell(input string tag, input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++) begin
            pix(i == 0, 1'b0, 1'b0);
            chk(tag, bus.rgbi, exp[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.enable = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_regs(input logic [3:0] cth, input logic [3:0] cdh,
                            input rgbi_t fg, input rgbi_t bg, input bit atr, input bit text);
        bus.reg_cth  = cth;
        bus.reg_cdh  = cdh;
        bus.reg_fg   = fg;
        bus.reg_bg   = bg;
        bus.reg_atr  = atr;
        bus.reg_text = text;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 0; bus.newCol = 0; bus.lineStart = 0; bus.frameStart = 0;
        bus.visible = 0; bus.line = 5'd0; bus.rowbuf = 0;
        bus.reg_rvs = 0; bus.reg_semi = 0; bus.reg_dbl = 0;
        bus.reg_ul = 5'd31; bus.reg_cbrate = 0;
        set_regs(4'd7, 4'd8, 4'hF, 4'h0, 1'b0, 1'b0);
        fill(8'h00, 8'h00);
        m_ci = 0; m_ai = 0; m_n = 0; m_frames = 0; m_chr = '0; m_atr = '0; m_rgbi = '0;

        do_reset();
        chk("reset", bus.rgbi, 4'h0);

        // Text, no attributes
        fill(8'hA5, 8'h00);
        pix(1'b1, 1'b1, 1'b0);
        chk("text_p0", bus.rgbi, 4'hF);
        run_cell("text", 8, 64'h0000_0000_F0F0_0F0F);

        // Attributes: reverse and underline
        set_regs(4'd7, 4'd8, 4'hF, 4'h1, 1'b1, 1'b0);
        fill(8'hF0, 8'h42);
        run_cell("attr_rev", 8, 64'h0000_0000_1111_2222);
        fill(8'hF0, 8'h22);
        bus.line = 5'd9; bus.reg_ul = 5'd9;
        run_cell("attr_ul", 8, 64'h0000_0000_2222_2222);
        bus.reg_ul = 5'd31;

        // Blink at 1/16 frames
        do_reset();
        set_regs(4'd7, 4'd8, 4'hF, 4'h0, 1'b1, 1'b0);
        fill(8'hFF, 8'h13);
        for (int f = 0; f <= 16; f++) begin
            run_cell("blink", 8, (((f / 8) % 2) == 1) ? 64'h0000_0000_3333_3333 : 64'h0);
            bus.enable = 1'b1; bus.visible = 1'b0; bus.frameStart = 1'b1;
            tick();
            bus.frameStart = 1'b0; bus.visible = 1'b1;
        end

        // Displayed width and semigraphics
        set_regs(4'd11, 4'd10, 4'hF, 4'h0, 1'b0, 1'b0);
        fill(8'h01, 8'h00);
        bus.reg_semi = 1'b1;
        run_cell("semi1", 12, 64'h0000_0000_000F_FF00);
        bus.reg_semi = 1'b0;
        run_cell("semi0", 12, 64'h0000_0000_000F_0000);

        // Double pixel, then bitmap mode with attribute colours
        set_regs(4'd7, 4'd8, 4'hF, 4'h0, 1'b0, 1'b0);
        fill(8'hA5, 8'h00);
        bus.reg_dbl = 1'b1;
        run_cell("dbl", 16, 64'hFF00_FF00_00FF_00FF);
        bus.reg_dbl = 1'b0;
        set_regs(4'd7, 4'd8, 4'hF, 4'h0, 1'b1, 1'b1);
        fill(8'h80, 8'h5A);
        run_cell("bitmap", 8, 64'h0000_0000_A555_5555);

        // lineStart with newCol, charbuf index wrap
        set_regs(4'd7, 4'd8, 4'hF, 4'h0, 1'b0, 1'b0);
        fill(8'h00, 8'h00);
        bus.charbuf[0] = 8'h80;
        for (int i = 0; i < 3; i++) pix(1'b1, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 1'b0);
        chk("ls_nc_slot0", bus.rgbi, 4'hF);
        pix(1'b1, 1'b0, 1'b0);
        chk("ls_nc_slot1", bus.rgbi, 4'h0);
        for (int i = 2; i < 8; i++) begin
            pix(1'b1, 1'b0, 1'b0);
            chk("ci_slot", bus.rgbi, 4'h0);
        end
        pix(1'b1, 1'b0, 1'b0);
        chk("ci_wrap", bus.rgbi, 4'hF);

        // Reset mid-cell
        pix(1'b1, 1'b0, 1'b0);
        pix(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("rst_mid", bus.rgbi, 4'h0);
        reset = 1'b0;
        bus.enable = 1'b0;
        tick();
        chk("rst_hold", bus.rgbi, 4'h0);
        pix(1'b1, 1'b0, 1'b0);
        chk("rst_slot0", bus.rgbi, 4'hF);

        // Randomized cells
        for (int c = 0; c < 200; c++) begin
            set_regs(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            bus.reg_rvs    = 1'($urandom);
            bus.reg_semi   = 1'($urandom);
            bus.reg_dbl    = 1'($urandom);
            bus.reg_cbrate = 1'($urandom);
            bus.reg_ul     = 5'($urandom_range(0, 3));
            bus.line       = 5'($urandom_range(0, 3));
            bus.rowbuf     = 1'($urandom);
            for (int i = 0; i < CW; i++) bus.charbuf[i] = 8'($urandom);
            for (int r = 0; r < 2; r++)
                for (int i = 0; i < SW; i++) bus.attrbuf[r][i] = 8'($urandom);
            pix(1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            for (int j = 0; j < int'($urandom_range(0, 20)); j++) begin
                bus.enable     = ($urandom_range(0, 3) != 0);
                bus.visible    = ($urandom_range(0, 7) != 0);
                bus.lineStart  = ($urandom_range(0, 15) == 0);
                bus.frameStart = ($urandom_range(0, 3) == 0);
                bus.line       = 5'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) bus.reg_rvs = ~bus.reg_rvs;
                tick();
            end
            bus.lineStart  = 1'b0;
            bus.frameStart = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
